gdp_bcd_sink: RTL and testbench

- Downstream consumer of the general data path.
- Watches the GDP `done` flag and captures the 8-bit running sum on its rising edge.
- Converts the captured value to 3-digit packed BCD using a sequential shift-add-3 (double-dabble) engine.
- Presents the result on a valid/ready handshake for a display or host stage.

---
 rtl/gdp_pkg.sv | 6 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/gdp_bcd_sink.sv | 91 +++++++++
 tb/tb_gdp_bcd_sink.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/gdp_pkg.sv
// gdp_pkg: shared GDP/sink constants and sink FSM state encodings
package gdp_pkg;
  localparam int GDP_WIDTH  = 8;
  localparam int BCD_DIGITS = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit cell, adds 3 when the digit is 5 or more
//   d  - current BCD digit
//   q  - adjusted digit, ready to be shifted left
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/gdp_bcd_sink.sv
// gdp_bcd_sink: captures run_sum on the rising edge of done and converts it to packed BCD
//   clock, reset_n     - clock and synchronous active-low reset
//   run_sum, done      - GDP running sum and its done/output-enable level
//   bcd_out, bcd_valid - packed BCD result (ones in [3:0]) and its valid flag
//   bcd_ready          - consumer accept; a transfer happens when valid and ready are both high
//   busy, overrun      - converting or holding a result; sticky dropped-capture flag
module gdp_bcd_sink
  import gdp_pkg::*;
#(
  parameter int WIDTH  = GDP_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    run_sum,
  input  logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                bcd_valid,
  input  logic                bcd_ready,
  output logic                busy,
  output logic                overrun
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t                      state;
  logic                        done_q;
  logic [CW-1:0]               count;
  logic [WIDTH-1:0]            bin_reg;
  logic [4*DIGITS-1:0]         acc;
  logic [4*DIGITS-1:0]         adj;
  logic [4*DIGITS+WIDTH-1:0]   sh;
  logic                        rise;
  assign rise = done & ~done_q;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(acc[4*i +: 4]), .q(adj[4*i +: 4]));
  end
  // Adjusted accumulator and remaining binary bits shift as one register.
  assign sh = {adj, bin_reg} << 1;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      done_q    <= 1'b0;
      count     <= '0;
      bin_reg   <= '0;
      acc       <= '0;
    end else begin
      done_q <= done;
      case (state)
        IDLE: if (rise) begin
          bin_reg <= run_sum;
          acc     <= '0;
          count   <= '0;
          busy    <= 1'b1;
          state   <= SHIFT;
        end
        SHIFT: begin
          {acc, bin_reg} <= sh;
          count          <= count + 1'b1;
          if (rise) overrun <= 1'b1;
          if (count == LAST) begin
            bcd_out   <= sh[4*DIGITS+WIDTH-1:WIDTH];
            bcd_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: if (bcd_ready) begin
          bcd_valid <= 1'b0;
          // A rise coinciding with acceptance starts the next conversion directly.
          if (rise) begin
            bin_reg <= run_sum;
            acc     <= '0;
            count   <= '0;
            state   <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end else if (rise) overrun <= 1'b1;
        default: begin
          bcd_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gdp_bcd_sink.sv
// tb_gdp_bcd_sink: scoreboard bench for gdp_bcd_sink
module tb_gdp_bcd_sink;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  run_sum = '0;
  logic        done = 1'b0;
  logic [11:0] bcd_out;
  logic        bcd_valid;
  logic        bcd_ready = 1'b1;
  logic        busy;
  logic        overrun;
  int          total = 0;
  int          bad = 0;
  logic [11:0] sb[$];

  gdp_bcd_sink dut (
    .clock(clock), .reset_n(reset_n), .run_sum(run_sum), .done(done),
    .bcd_out(bcd_out), .bcd_valid(bcd_valid), .bcd_ready(bcd_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int want, input string name);
    int n;
    for (n = 1; n <= 30; n++) begin
      tick;
      if (n == 1) done = 1'b0;
      if (bcd_valid) break;
    end
    total++;
    if (n !== want) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, n, want);
    end
  endtask

  task automatic check_pop(input string name);
    logic [11:0] e;
    e = sb.size() > 0 ? sb.pop_front() : 12'hxxx;
    total++;
    if (bcd_out !== e) begin
      bad++;
      $display("FAIL %s bcd_out: got %h, want %h", name, bcd_out, e);
    end
  endtask

  task automatic start(input logic [7:0] v);
    done = 1'b1;
    run_sum = v;
    sb.push_back(to_bcd(int'(v)));
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick;
    tick;
    total += 4;
    if (bcd_out !== 12'h000) begin bad++; $display("FAIL reset bcd_out: got %h, want 000", bcd_out); end
    if (bcd_valid !== 1'b0) begin bad++; $display("FAIL reset bcd_valid: got %b, want 0", bcd_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b, want 0", busy); end
    if (overrun !== 1'b0) begin bad++; $display("FAIL reset overrun: got %b, want 0", overrun); end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_convert;
    logic [7:0] vals[5] = '{8'd55, 8'd255, 8'd0, 8'd253, 8'd20};
    bcd_ready = 1'b1;
    foreach (vals[i]) begin
      start(vals[i]);
      wait_valid(9, "convert");
      check_pop("convert");
      tick;
      total++;
      if (bcd_valid !== 1'b0) begin bad++; $display("FAIL convert one_cycle valid: got %b, want 0", bcd_valid); end
      tick;
    end
  endtask

  task automatic test_stall;
    logic [11:0] e;
    bcd_ready = 1'b0;
    start(8'd123);
    e = to_bcd(123);
    wait_valid(9, "stall");
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin done = 1'b1; run_sum = 8'd77; end
      if (c == 6) done = 1'b0;
      total++;
      if (bcd_valid !== 1'b1 || bcd_out !== e) begin
        bad++;
        $display("FAIL stall hold: got valid=%b out=%h, want valid=1 out=%h", bcd_valid, bcd_out, e);
      end
      tick;
    end
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL stall overrun: got %b, want 1", overrun); end
    check_pop("stall");
    bcd_ready = 1'b1;
    tick;
    for (int c = 0; c < 15; c++) begin
      total++;
      if (bcd_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL stall dropped: got valid=%b busy=%b, want 0 0", bcd_valid, busy);
      end
      tick;
    end
  endtask

  task automatic test_simultaneous;
    test_reset;
    bcd_ready = 1'b0;
    start(8'd42);
    wait_valid(9, "simul_first");
    tick;
    check_pop("simul_first");
    bcd_ready = 1'b1;
    start(8'd99);
    tick;
    done = 1'b0;
    total += 3;
    if (bcd_valid !== 1'b0) begin bad++; $display("FAIL simul valid_drop: got %b, want 0", bcd_valid); end
    if (busy !== 1'b1) begin bad++; $display("FAIL simul busy: got %b, want 1", busy); end
    if (overrun !== 1'b0) begin bad++; $display("FAIL simul overrun: got %b, want 0", overrun); end
    wait_valid(8, "simul_second");
    check_pop("simul_second");
    tick;
  endtask

  task automatic test_reset_mid;
    bcd_ready = 1'b1;
    start(8'd200);
    tick;
    done = 1'b0;
    tick;
    done = 1'b1;
    tick;
    tick;
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL mid overrun_set: got %b, want 1", overrun); end
    reset_n = 1'b0;
    sb.delete();
    tick;
    total += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid busy: got %b, want 0", busy); end
    if (bcd_valid !== 1'b0) begin bad++; $display("FAIL mid valid: got %b, want 0", bcd_valid); end
    if (bcd_out !== 12'h000) begin bad++; $display("FAIL mid bcd_out: got %h, want 000", bcd_out); end
    if (overrun !== 1'b0) begin bad++; $display("FAIL mid overrun_clr: got %b, want 0", overrun); end
    start(8'd200);
    reset_n = 1'b1;
    wait_valid(9, "mid_recapture");
    check_pop("mid_recapture");
    tick;
  endtask

  initial begin
    test_reset;
    test_convert;
    test_stall;
    test_simultaneous;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
